// File: rtl/nerv_pkg.sv
// Shared types and parameter defaults for the nerv lock initiator.
package nerv_pkg;

  localparam int unsigned WR_CYCLES_DEF      = 3;
  localparam int unsigned RD_WAIT_DEF        = 2;
  localparam int unsigned MAX_FAIL_DEF       = 3;
  localparam int unsigned LOCKOUT_CYCLES_DEF = 16;
  localparam int unsigned WORD_W             = 16;
  localparam int unsigned TMR_W              = 16;
  localparam int unsigned FAIL_W             = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_GAP     = 3'd2,
    S_READ    = 3'd3,
    S_DONE    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_e;

endpackage

// File: rtl/nerv_cycle_timer.sv
// Loadable down-counter; o_zero_c flags the last cycle of a timed phase.
module nerv_cycle_timer
  import nerv_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  output logic             o_zero_c
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TMR_W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/nerv_initiator.sv
// Drives one write/read unlock attempt against a lock and tracks failures.
// Optional lockout after repeated failures is enabled by NERV_LOCKOUT_EN.
module nerv_initiator
  import nerv_pkg::*;
#(
  parameter int unsigned WR_CYCLES      = WR_CYCLES_DEF,
  parameter int unsigned RD_WAIT        = RD_WAIT_DEF,
  parameter int unsigned MAX_FAIL       = MAX_FAIL_DEF,
  parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  word_t             code,
  output logic              cs,
  output logic              wr,
  output logic              rd,
  output word_t             data_out,
  input  logic              pass_in,
  input  word_t             lock_in,
  output logic              busy,
  output logic              done,
  output logic              granted,
  output logic              locked_out,
  output word_t             status,
  output logic [FAIL_W-1:0] fail_cnt
);

  state_e             r_state;
  state_e             w_state_nxt;
  word_t              r_code;
  word_t              w_code;
  logic               w_tmr_load;
  logic [TMR_W-1:0]   w_tmr_val;
  logic               w_tmr_zero;
  logic               w_sample;
  logic               w_fail_clr;
  logic               w_cs, w_wr, w_rd, w_busy, w_done, w_lock;
  word_t              w_data;
  logic               r_cs, r_wr, r_rd, r_busy, r_done, r_granted, r_lock;
  word_t              r_data, r_status;
  logic [FAIL_W-1:0]  r_fail;

  nerv_cycle_timer u_timer (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero_c   (w_tmr_zero)
  );

  // The code is forwarded straight through on the accepting edge.
  assign w_code = (r_state == S_IDLE) ? code : r_code;

  // Next state, timer control and the output values for the next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_sample    = 1'b0;
    w_fail_clr  = 1'b0;
    w_cs        = 1'b0;
    w_wr        = 1'b0;
    w_rd        = 1'b0;
    w_data      = '0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_lock      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_WRITE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TMR_W'(WR_CYCLES - 1);
        end
      end
      S_WRITE: if (w_tmr_zero) w_state_nxt = S_GAP;
      S_GAP: begin
        w_state_nxt = S_READ;
        w_tmr_load  = 1'b1;
        w_tmr_val   = TMR_W'(RD_WAIT - 1);
      end
      S_READ: begin
        if (w_tmr_zero) begin
          w_state_nxt = S_DONE;
          w_sample    = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
`ifdef NERV_LOCKOUT_EN
        if (!r_granted && r_fail == FAIL_W'(MAX_FAIL)) begin
          w_state_nxt = S_LOCKOUT;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TMR_W'(LOCKOUT_CYCLES - 1);
        end
`endif
      end
`ifdef NERV_LOCKOUT_EN
      S_LOCKOUT: begin
        if (w_tmr_zero) begin
          w_state_nxt = S_IDLE;
          w_fail_clr  = 1'b1;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_WRITE: begin
        w_cs   = 1'b1;
        w_wr   = 1'b1;
        w_data = w_code;
      end
      S_GAP: ;
      S_READ: begin
        w_cs = 1'b1;
        w_rd = 1'b1;
      end
      S_DONE: w_done = 1'b1;
`ifdef NERV_LOCKOUT_EN
      S_LOCKOUT: w_lock = 1'b1;
`endif
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_code    <= '0;
      r_cs      <= 1'b0;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_lock    <= 1'b0;
      r_granted <= 1'b0;
      r_status  <= '0;
      r_fail    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cs    <= w_cs;
      r_wr    <= w_wr;
      r_rd    <= w_rd;
      r_data  <= w_data;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_lock  <= w_lock;
      if (r_state == S_IDLE && start) r_code <= code;
      if (w_sample) begin
        r_granted <= pass_in;
        r_status  <= lock_in;
        if (pass_in) r_fail <= '0;
        else if (r_fail != '1) r_fail <= r_fail + FAIL_W'(1);
      end else if (w_fail_clr) begin
        r_fail <= '0;
      end
    end
  end

`ifndef NERV_LOCKOUT_EN
  logic w_unused_cfg;
  assign w_unused_cfg = ^{32'(MAX_FAIL), 32'(LOCKOUT_CYCLES), r_lock};
`endif

  assign cs       = r_cs;
  assign wr       = r_wr;
  assign rd       = r_rd;
  assign data_out = r_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign granted  = r_granted;
  assign status   = r_status;
  assign fail_cnt = r_fail;
`ifdef NERV_LOCKOUT_EN
  assign locked_out = r_lock;
`else
  assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_nerv_initiator.sv
// Self-checking bench for nerv_initiator: vector table, hand sequences and random attempts.
module tb_nerv_initiator;
  import nerv_pkg::*;

  localparam int WR = 3;
  localparam int RD = 2;
  localparam int MF = 3;
  localparam int LC = 16;
  localparam int D  = WR + RD + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  word_t       code = '0;
  logic        cs, wr, rd, busy, done, granted, locked_out;
  word_t       data_out, status;
  word_t       lock_in = '0;
  logic        pass_in = 1'b0;
  logic [3:0]  fail_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: result of the last attempt and failure streak.
  logic        m_granted = 1'b0;
  word_t       m_status  = '0;
  int          m_fail    = 0;

  typedef struct packed {
    logic cs, wr, rd, busy, done, granted, locked_out;
    word_t data, status;
    logic [3:0] fail;
  } obs_t;

  typedef struct {
    word_t code;
    logic  pass;
    word_t lock;
    int    alt_start;
    bit    chg;
    logic  e_granted;
    word_t e_status;
    int    e_fail;
  } vec_t;

  nerv_initiator #(
    .WR_CYCLES(WR), .RD_WAIT(RD), .MAX_FAIL(MF), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .code(code),
    .cs(cs), .wr(wr), .rd(rd), .data_out(data_out),
    .pass_in(pass_in), .lock_in(lock_in),
    .busy(busy), .done(done), .granted(granted), .locked_out(locked_out),
    .status(status), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o = '{cs: cs, wr: wr, rd: rd, busy: busy, done: done, granted: granted,
          locked_out: locked_out, data: data_out, status: status, fail: fail_cnt};
    return o;
  endfunction

  task automatic chk(input string name, input obs_t exp);
    obs_t act;
    act = observe();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic obs_t idle_exp();
    obs_t e;
    e = '0;
    e.granted = m_granted;
    e.status  = m_status;
    e.fail    = 4'(m_fail);
    return e;
  endfunction

  // Bus invariants hold in every cycle.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ((wr && rd) || (!wr && data_out != '0)) begin
        errors++;
        $display("FAIL bus_invariant wr=%b rd=%b data=%h exp no overlap and zero data", wr, rd, data_out);
      end
    end
  end

  // One attempt, cycle by cycle from the accepting edge; expected outputs come from the attempt timeline.
  task automatic attempt(input word_t c, input logic p, input word_t lk, input int alt_start,
                         input bit chg, input bit tbl, input logic eg, input word_t es, input int ef);
    obs_t e;
    bit   lock;
    int   nw;
    @(negedge clk);
    chk("cycle0_idle", idle_exp());
    start = 1'b1;
    code  = c;
    lock  = 1'b0;
    @(negedge clk);
    for (int n = 1; n <= D + LC + 1; n++) begin
      if (n == D) begin
        m_granted = p;
        m_status  = lk;
        m_fail    = p ? 0 : ((m_fail >= 15) ? 15 : m_fail + 1);
`ifdef NERV_LOCKOUT_EN
        lock = !p && (m_fail == MF);
`endif
      end
      if (lock && n == D + LC + 1) m_fail = 0;
      e = idle_exp();
      e.wr   = (n >= 1 && n <= WR);
      e.rd   = (n >= WR + 2 && n <= WR + 1 + RD);
      e.cs   = e.wr | e.rd;
      e.data = e.wr ? c : '0;
      e.done = (n == D);
      e.busy = (n <= D) || (lock && n <= D + LC);
      e.locked_out = lock && n > D && n <= D + LC;
      chk($sformatf("attempt_cycle%0d", n), e);
      if (tbl && n == D) begin
        chk_val("tbl_granted", 32'(granted), 32'(eg));
        chk_val("tbl_status", 32'(status), 32'(es));
        chk_val("tbl_fail", 32'(fail_cnt), 32'(ef));
      end
      if (!e.busy) break;
      start   = (n == alt_start);
      nw      = $urandom;
      if (chg && n == 2) code = ~c;
      if (n == alt_start) code = 16'(nw);
      pass_in = (n == D - 1) ? p : 1'($urandom);
      lock_in = (n == D - 1) ? lk : 16'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    obs_t z;
    z = '0;
    tbl[0] = '{16'd5423, 1'b1, 16'h0001, 0, 1'b0, 1'b1, 16'h0001, 0};
    tbl[1] = '{16'h1111, 1'b0, 16'hDEAD, 0, 1'b0, 1'b0, 16'hDEAD, 1};
    tbl[2] = '{16'h1234, 1'b1, 16'h00AA, 3, 1'b1, 1'b1, 16'h00AA, 0};
    tbl[3] = '{16'h0F0F, 1'b0, 16'hBEEF, D, 1'b0, 1'b0, 16'hBEEF, 1};
    tbl[4] = '{16'hA5A5, 1'b0, 16'h0000, 5, 1'b1, 1'b0, 16'h0000, 2};
    tbl[5] = '{16'h7777, 1'b1, 16'hFFFF, 1, 1'b0, 1'b1, 16'hFFFF, 0};

    #1 reset = 1'b0;
    #2 chk("reset_state", z);
    repeat (2) @(negedge clk);
    chk("reset_held", z);
    reset = 1'b1;

    foreach (tbl[i])
      attempt(tbl[i].code, tbl[i].pass, tbl[i].lock, tbl[i].alt_start, tbl[i].chg,
              1'b1, tbl[i].e_granted, tbl[i].e_status, tbl[i].e_fail);

    // Three consecutive failures, with a start attempt in the middle of any lockout.
    for (int k = 0; k < 3; k++)
      attempt(16'h3000 + 16'(k), 1'b0, 16'hC0DE, D + 5, 1'b0, 1'b0, 1'b0, '0, 0);
    attempt(16'h4242, 1'b1, 16'h0042, 0, 1'b0, 1'b0, 1'b0, '0, 0);

    // Long failure run exercises saturation (or repeated lockouts).
    for (int k = 0; k < 17; k++)
      attempt(16'(k), 1'b0, 16'(k * 3), 0, 1'b0, 1'b0, 1'b0, '0, 0);

    for (int k = 0; k < 40; k++)
      attempt(16'($urandom), ($urandom_range(0, 3) == 0), 16'($urandom),
              $urandom_range(0, D + LC), 1'($urandom), 1'b0, 1'b0, '0, 0);

    // Reset in the first READ cycle releases everything asynchronously.
    @(negedge clk);
    start = 1'b1;
    code  = 16'h5A5A;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk_val("pre_reset_rd", 32'(rd), 32'd1);
    #2 reset = 1'b0;
    #1 chk("async_reset_mid_read", z);
    @(negedge clk);
    reset = 1'b1;
    m_granted = 1'b0;
    m_status  = '0;
    m_fail    = 0;
    attempt(16'd5423, 1'b1, 16'h0BAD, 0, 1'b0, 1'b1, 1'b1, 16'h0BAD, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nerv_initiator.md
NERV_INITIATOR -- requirements
Module: nerv_initiator

Interface
REQ-001 Parameter WR_CYCLES, default 3, SHALL set the number of cycles cs/wr/data_out are held per write.
REQ-002 Parameter RD_WAIT, default 2, SHALL set the number of cycles cs/rd are held per read; the sample is taken on the last one.
REQ-003 Parameter MAX_FAIL, default 3, SHALL set the consecutive-failure count that triggers lockout.
REQ-004 Parameter LOCKOUT_CYCLES, default 16, SHALL set the lockout duration in cycles.
REQ-005 Port clk, input, 1: single clock; all logic SHALL be rising-edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port start, input, 1: request one unlock attempt.
REQ-008 Port code, input, 16: password to present; captured on accepted start.
REQ-009 Port cs, wr, rd, output, 1 each: lock-side bus strobes.
REQ-010 Port data_out, output, 16: password driven to the lock data_in.
REQ-011 Port pass_in, input, 1: lock pass indication.
REQ-012 Port lock_in, input, 16: lock status word.
REQ-013 Port busy, done, granted, locked_out, output, 1 each: attempt in progress; one-cycle completion pulse; result of last attempt; lockout active.
REQ-014 Port status, output, 16: lock_in sampled on the last attempt.
REQ-015 Port fail_cnt, output, 4: consecutive failed attempts, saturating at 15.

Function
REQ-016 FSM states SHALL be IDLE, WRITE, GAP, READ, DONE, LOCKOUT.
REQ-017 IDLE: start=1 SHALL capture code and move to WRITE; otherwise remain in IDLE.
REQ-018 WRITE: cs=1, wr=1, rd=0, data_out=captured code for exactly WR_CYCLES cycles, then GAP.
REQ-019 GAP: cs=wr=rd=0 for exactly 1 cycle, then READ.
REQ-020 READ: cs=1, rd=1, wr=0 for RD_WAIT cycles; pass_in and lock_in SHALL be registered on the last READ cycle; then DONE.
REQ-021 DONE: done=1 for exactly 1 cycle; granted=sampled pass_in; status=sampled lock_in; next state IDLE, or LOCKOUT per REQ-030.
REQ-022 Latency: start accepted at cycle 0 SHALL give done at cycle 1+WR_CYCLES+1+RD_WAIT (cycle 7 at defaults).
REQ-023 data_out SHALL be 0 outside WRITE; wr and rd SHALL never be high together.
REQ-024 busy SHALL be 1 in WRITE, GAP, READ, DONE and LOCKOUT.
REQ-025 start SHALL be ignored when the FSM is not in IDLE, including in DONE and LOCKOUT; there is no queuing.
REQ-026 granted and status SHALL hold their values until the next DONE.
REQ-027 DONE with granted=1 SHALL clear fail_cnt; DONE with granted=0 SHALL increment fail_cnt, saturating at 15.
REQ-028 code changes after capture SHALL NOT affect data_out.

Reset
REQ-029 reset=0 SHALL immediately force IDLE; cs, wr, rd, data_out, busy, done, granted, locked_out, status and fail_cnt = 0, including mid-attempt and mid-lockout; the bus SHALL be released within the same cycle.

Configuration
REQ-030 With NERV_LOCKOUT_EN defined: DONE with granted=0 that makes fail_cnt equal MAX_FAIL SHALL enter LOCKOUT; locked_out=1 and the strobes are 0 for LOCKOUT_CYCLES cycles; fail_cnt SHALL then clear and the FSM SHALL return to IDLE.
REQ-031 Without NERV_LOCKOUT_EN: the LOCKOUT state and its timer SHALL NOT be built, locked_out SHALL be constant 0, and fail_cnt only saturates.

Structure
REQ-032 Package nerv_pkg SHALL hold the state enum, the parameter defaults and the 16-bit word typedef.
REQ-033 One sub-module, nerv_cycle_timer (a loadable down-counter with a zero flag), SHALL time the WRITE, READ and LOCKOUT states.

Verification
REQ-034 code=5423, pass_in=1 during READ -> wr high in cycles 1-3 with data_out=5423, GAP in cycle 4, rd high in cycles 5-6, done in cycle 7, granted=1, fail_cnt=0.
REQ-035 pass_in=0, lock_in=16'hDEAD -> done in cycle 7, granted=0, status=16'hDEAD, fail_cnt=1.
REQ-036 NERV_LOCKOUT_EN defined, three failed attempts -> locked_out=1 for 16 cycles; a start during lockout is ignored; afterwards fail_cnt=0 and a new start is accepted.
REQ-037 start pulsed in cycle 3 of an attempt and code changed mid-write -> no second attempt; data_out stays at the captured code.
REQ-038 reset low in READ cycle 5 -> all outputs 0 asynchronously; after release, a start gives a full 7-cycle attempt.
